enc_frame_loader: RTL and testbench
===================================

# enc_frame_loader

Byte-stream front end for the encode/16-QAM transmit chain. Accepts bytes over a valid/ready handshake, packs them into 64-bit frames, and drives the encoder's `data_in`/`start` pair one frame at a time. It waits for the encoder's `done` before issuing the next frame. A one-frame pending buffer lets byte intake continue while the encoder is busy.

## Interface
- `MSB_FIRST`, default 1: 1 puts the first byte in [63:56]; 0 puts it in [7:0].
- `TIMEOUT`, default 4096: maximum cycles to wait for `enc_done` after `start`.
- `CNT_W`, default 16: width of `frames_sent`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `s_data` in 8: input byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: byte closes the current frame, qualified by `s_valid`.
- `s_ready` out 1: block can accept a byte.
- `data_out` out 64: frame to the encoder's `data_in`.
- `start` out 1: one-cycle pulse to the encoder.
- `enc_done` in 1: encoder `done`, a level.
- `busy` out 1: a frame is issued and awaiting completion.
- `err_timeout` out 1: sticky; set when a wait exceeds `TIMEOUT`.
- `frames_sent` out CNT_W: count of completed frames; wraps.

## Operation
- **Byte transfer:** occurs when `s_valid && s_ready`.
- **Assembly register:**
  - `idx` runs 0..7.
  - A frame completes when the byte at `idx`=7 transfers, or when a transfer has `s_last`=1.
  - Unfilled byte lanes are zero.
  - `idx` returns to 0 after completion.
- **Pending register:** one frame deep.
  - A completed frame moves into pending on the same clock edge if pending is empty, or if pending is being consumed that cycle.
  - Otherwise the assembly register holds the completed frame and `s_ready` drops to 0.
- **`s_ready`:** equals `!(asm_full && pend_full) && !reset`.
- **Issue FSM:** states IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when pending is full. `data_out` is loaded from pending at that point.
  - ISSUE: `start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: capture the previous `enc_done` each cycle.
    - On a rising edge (`enc_done` && !`prev`): increment `frames_sent`, free pending, go to IDLE.
    - If the wait counter reaches `TIMEOUT` first: set `err_timeout`, free pending (frame dropped), go to IDLE.
- **`data_out`:** held stable from ISSUE until the next ISSUE.
- **`busy`:** 1 in ISSUE and WAIT.
- **Priority:** pending free and assembly completion in the same cycle → the new frame goes straight to pending and the FSM re-issues from IDLE next cycle. No bubble beyond IDLE.
- **Back-to-back frames:** minimum spacing is IDLE + ISSUE + WAIT ≥ 3 cycles.

## Timing
- **Reset values:**
  - `s_ready`=0 during reset, then 1.
  - `data_out`=0, `start`=0, `busy`=0, `err_timeout`=0, `frames_sent`=0.
  - `idx`=0; pending and assembly empty; FSM=IDLE.
- **Latency:** the last byte of a frame is accepted at edge N, with pending empty and FSM in IDLE.
  - Pending is full after edge N.
  - FSM is in ISSUE after edge N+1; `start`=1 during cycle N+1..N+2 with `data_out` valid.
- **`enc_done` already high at ISSUE:** not a rising edge. The block waits for it to fall and rise again.
- **Reset mid-frame or mid-wait:** partial bytes, pending, and the in-flight frame are all dropped. No `start` is generated.
- **`frames_sent`:** wraps at 2^CNT_W−1 → 0.
- **Short frames:** a one-byte frame (`s_last` at `idx`=0) is legal. A frame is never empty.

## Structure
- Shared package `enc_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT).
  - `FRAME_BYTES`=8, `FRAME_W`=64.
- Single module with no submodules. The byte-lane packer is a function in the package: `pack_byte(word, idx, byte, msb_first)`.

## Test plan
- **Full frame:** bytes 01..08, MSB_FIRST=1, no `s_last`, encoder pulses `enc_done` 10 cycles after `start` → `data_out`=0x0102030405060708, one `start` pulse, `frames_sent`=1.
- **Short frame:** 3 bytes AA,BB,CC with `s_last` on CC, MSB_FIRST=0 → `data_out`=0x0000000000CCBBAA.
- **Backpressure:** stream 24 bytes continuously while the encoder takes 40 cycles per frame.
  - `s_ready` drops after byte 16.
  - Three `start` pulses in order, no byte lost, `frames_sent`=3.
- **Timeout:** TIMEOUT=16 and `enc_done` held 0 → `err_timeout`=1 at cycle 16 of WAIT, `frames_sent` unchanged. The next frame still issues.
- **Level `done`:** `enc_done` stuck high from before ISSUE → no completion until the level falls and rises again.
- **Reset mid-WAIT:** assert `reset` with 5 bytes in assembly → all outputs return to reset values. The next 8 bytes form a clean frame.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder front end.
//
// Contents:
//   FRAME_BYTES / FRAME_W : frame geometry (8 bytes, 64 bits)
//   IDX_W                 : width of the byte-lane index inside a frame
//   fsm_state_t           : issue FSM states (IDLE, ISSUE, WAIT)
//   pack_byte()           : drops one byte into its lane of a frame word
package enc_pkg;

  localparam int FRAME_BYTES = 8;
  localparam int FRAME_W     = 64;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fsm_state_t;

  // Returns `word` with `data` written into the lane selected by `idx`.
  // With msb_first set, byte 0 of the frame lands in the top lane, so the
  // lane number is the bitwise complement of idx (7 - idx for 3 bits).
  function automatic logic [FRAME_W-1:0] pack_byte(
    input logic [FRAME_W-1:0] word,
    input logic [IDX_W-1:0]   idx,
    input logic [7:0]         data,
    input logic               msb_first
  );
    logic [FRAME_W-1:0] result;
    logic [IDX_W-1:0]   lane;
    result = word;
    lane   = msb_first ? ~idx : idx;
    result[{lane, 3'b000} +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/enc_frame_loader.sv
// Byte-stream front end for the encode / 16-QAM transmit chain.
//
// Bytes arrive over a valid/ready handshake and are packed into 64-bit
// frames. Completed frames go through a one-deep pending register to an
// issue FSM that presents the frame on data_out, pulses start for one
// cycle and then waits for a rising edge of the encoder's done level.
// The assembly register doubles as a second buffer: when pending is
// occupied a completed frame stays in assembly and intake stalls.
//
// Parameters:
//   MSB_FIRST   1: first byte in [63:56]; 0: first byte in [7:0]
//   TIMEOUT     WAIT cycles allowed before the frame is dropped
//   CNT_W       width of frames_sent
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   byte input handshake
//   data_out, start     frame and one-cycle start pulse to the encoder
//   enc_done            encoder done level
//   busy                frame issued and not yet completed
//   err_timeout         sticky, set when a wait hits TIMEOUT
//   frames_sent         completed frame count, wraps
module enc_frame_loader
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 4096,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [FRAME_W-1:0] data_out,
  output logic               start,
  input  logic               enc_done,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   frames_sent
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  // Assembly register: partial frame, or a completed frame held back
  // because pending is still occupied (asm_full).
  logic [FRAME_W-1:0] asm_word;
  logic [IDX_W-1:0]   idx;
  logic               asm_full;

  // Pending register: the frame queued for, or in flight at, the encoder.
  logic [FRAME_W-1:0] pend_word;
  logic               pend_full;

  fsm_state_t         state;
  logic               prev_done;
  logic [WCNT_W-1:0]  wait_cnt;

  logic               xfer;
  logic               frame_done;
  logic [FRAME_W-1:0] new_word;
  logic               done_rise;
  logic               timed_out;
  logic               pend_free;
  logic               load_new;
  logic               load_held;

  // asm_full can only be set while pending is full, so this also
  // blocks intake whenever a completed frame is parked in assembly.
  assign s_ready    = !(asm_full && pend_full) && !reset;

  assign xfer       = s_valid && s_ready;
  // asm_word is kept zero between frames, so unfilled lanes stay zero.
  assign new_word   = pack_byte(asm_word, idx, s_data, MSB_FIRST);
  assign frame_done = xfer && ((idx == IDX_W'(FRAME_BYTES - 1)) || s_last);

  // prev_done tracks enc_done every cycle, so a level that is already
  // high when WAIT begins is not mistaken for a completion.
  assign done_rise  = enc_done && !prev_done;
  assign timed_out  = (wait_cnt == WCNT_W'(TIMEOUT - 1));
  assign pend_free  = (state == WAIT) && (done_rise || timed_out);

  // A freshly completed frame goes straight to pending when pending is
  // empty or being released this very cycle.
  assign load_new   = frame_done && (!pend_full || pend_free);
  // A parked frame follows as soon as pending is released. It is never
  // coincident with load_new because intake is stalled while parked.
  assign load_held  = asm_full && pend_free;

  // Byte assembly and pending buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_word  <= '0;
      idx       <= '0;
      asm_full  <= 1'b0;
      pend_word <= '0;
      pend_full <= 1'b0;
    end else begin
      if (frame_done) begin
        idx <= '0;
        if (load_new) begin
          asm_word <= '0;
        end else begin
          asm_word <= new_word;
          asm_full <= 1'b1;
        end
      end else if (xfer) begin
        asm_word <= new_word;
        idx      <= idx + IDX_W'(1);
      end else if (load_held) begin
        asm_word <= '0;
        asm_full <= 1'b0;
      end

      if (load_new) begin
        pend_word <= new_word;
        pend_full <= 1'b1;
      end else if (load_held) begin
        pend_word <= asm_word;
        pend_full <= 1'b1;
      end else if (pend_free) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Issue FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_out    <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      frames_sent <= '0;
      prev_done   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      prev_done <= enc_done;
      start     <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_full) begin
            state    <= ISSUE;
            data_out <= pend_word;
            start    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // A completion in the last allowed cycle wins over the timeout.
          if (done_rise) begin
            frames_sent <= frames_sent + CNT_W'(1);
            state       <= IDLE;
            busy        <= 1'b0;
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_frame_loader.sv
// Self-checking bench for enc_frame_loader. Two instances are exercised:
// lane 0 (MSB_FIRST=1, TIMEOUT=64, CNT_W=16) and lane 1 (MSB_FIRST=0,
// TIMEOUT=16, CNT_W=3). A frame-queue reference model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_enc_frame_loader;

  localparam int TMO [2] = '{64, 16};
  localparam int FSW [2] = '{16, 3};
  localparam bit MSB [2] = '{1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [7:0]  s_data   [2];
  logic        s_valid  [2];
  logic        s_last   [2];
  logic        s_ready  [2];
  logic        start    [2];
  logic        busy     [2];
  logic        err      [2];
  logic        enc_done [2] = '{1'b0, 1'b0};
  logic [63:0] dout0, dout1;
  logic [15:0] fs0;
  logic [2:0]  fs1;

  enc_frame_loader #(.MSB_FIRST(1'b1), .TIMEOUT(64), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .s_ready(s_ready[0]), .data_out(dout0), .start(start[0]),
    .enc_done(enc_done[0]), .busy(busy[0]), .err_timeout(err[0]), .frames_sent(fs0)
  );

  enc_frame_loader #(.MSB_FIRST(1'b0), .TIMEOUT(16), .CNT_W(3)) dut1 (
    .clk(clk), .reset(rst[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .s_ready(s_ready[1]), .data_out(dout1), .start(start[1]),
    .enc_done(enc_done[1]), .busy(busy[1]), .err_timeout(err[1]), .frames_sent(fs1)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;
  int cyc     = 0;

  function automatic logic [63:0] get_dout(input int ln);
    return (ln == 0) ? dout0 : dout1;
  endfunction

  function automatic int get_fs(input int ln);
    return (ln == 0) ? int'(fs0) : int'(fs1);
  endfunction

  task automatic check(input string name, input int ln, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %h expected %h (cycle %0d)", name, ln, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Completed frames wait in a queue of at most two (front = the one at
  // the encoder). m_ph: 0 no frame issued, 1 start cycle, 2 waiting.
  logic [63:0] m_q    [2][2];
  int          m_qn   [2] = '{0, 0};
  logic [63:0] m_part [2] = '{64'd0, 64'd0};
  int          m_nb   [2] = '{0, 0};
  int          m_ph   [2] = '{0, 0};
  int          m_wait [2] = '{0, 0};
  int          m_fs   [2] = '{0, 0};
  logic        m_prev [2] = '{1'b0, 1'b0};
  logic [63:0] e_data [2] = '{64'd0, 64'd0};
  logic        e_start[2] = '{1'b0, 1'b0};
  logic        e_busy [2] = '{1'b0, 1'b0};
  logic        e_err  [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int  n0;
      bit  pop;
      int  lane;
      n0  = m_qn[i];
      pop = 0;
      if (rst[i]) begin
        m_qn[i] = 0; m_part[i] = '0; m_nb[i] = 0; m_ph[i] = 0; m_wait[i] = 0;
        m_fs[i] = 0; m_prev[i] = 0; e_data[i] = '0; e_start[i] = 0;
        e_busy[i] = 0; e_err[i] = 0;
      end else begin
        e_start[i] = 0;
        if (m_ph[i] == 0) begin
          if (n0 > 0) begin
            m_ph[i] = 1; e_data[i] = m_q[i][0]; e_start[i] = 1; e_busy[i] = 1;
          end
        end else if (m_ph[i] == 1) begin
          m_ph[i] = 2; m_wait[i] = 0;
        end else begin
          m_wait[i]++;
          if (enc_done[i] && !m_prev[i]) begin
            m_fs[i]++; pop = 1;
          end else if (m_wait[i] == TMO[i]) begin
            e_err[i] = 1; pop = 1;
          end
          if (pop) begin m_ph[i] = 0; e_busy[i] = 0; end
        end
        if (pop) begin m_q[i][0] = m_q[i][1]; m_qn[i]--; end
        if (s_valid[i] && n0 < 2) begin
          lane = MSB[i] ? 7 - m_nb[i] : m_nb[i];
          m_part[i] = m_part[i] | (64'(s_data[i]) << (8 * lane));
          m_nb[i]++;
          if (m_nb[i] == 8 || s_last[i]) begin
            m_q[i][m_qn[i]] = m_part[i]; m_qn[i]++; m_part[i] = '0; m_nb[i] = 0;
          end
        end
        m_prev[i] = enc_done[i];
      end
    end
  end

  // ---------------- per-cycle compare + bookkeeping ----------------
  int          scnt [2] = '{0, 0};
  int          acc  [2] = '{0, 0};
  int          last_start_cyc [2] = '{0, 0};
  logic [63:0] log0 [$];
  bit          bp_watch = 0;
  int          acc_base = 0;
  int          stall_at = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("s_ready", i, s_ready[i], (!rst[i] && m_qn[i] < 2));
        check("start", i, start[i], e_start[i]);
        check("busy", i, busy[i], e_busy[i]);
        check("data_out", i, get_dout(i), e_data[i]);
        check("err_timeout", i, err[i], e_err[i]);
        check("frames_sent", i, get_fs(i), m_fs[i] % (1 << FSW[i]));
        if (start[i] === 1'b1) begin
          scnt[i]++;
          last_start_cyc[i] = cyc;
          if (i == 0) log0.push_back(dout0);
        end
        if (i == 0 && bp_watch && s_valid[0] && !s_ready[0] && stall_at < 0)
          stall_at = acc[0] - acc_base;
        if (s_valid[i] && s_ready[i]) acc[i]++;
      end
    end
  end

  // ---------------- encoder emulation ----------------
  // auto_m: 0 manual level from man_done, 1 fixed delay, 2 random delay.
  int   auto_m  [2] = '{0, 0};
  int   dly     [2] = '{10, 10};
  int   dmax    [2] = '{10, 10};
  int   dcnt    [2] = '{0, 0};
  logic man_done[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (auto_m[i] != 0) begin
        if (dcnt[i] > 0) begin
          dcnt[i]--;
          enc_done[i] = (dcnt[i] == 0);
        end else begin
          enc_done[i] = 1'b0;
        end
        if (start[i] === 1'b1)
          dcnt[i] = (auto_m[i] == 1) ? dly[i] : int'($urandom_range(dmax[i], 1));
      end else begin
        dcnt[i]     = 0;
        enc_done[i] = man_done[i];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one byte and returns 1 ns after the edge that accepted it.
  task automatic send_byte(input int ln, input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    s_valid[ln] = 1'b1; s_data[ln] = d; s_last[ln] = l;
    forever begin
      @(negedge clk);
      if (s_ready[ln] === 1'b1) break;
      guard++;
      if (guard > 600) begin
        check("byte_accept", ln, 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid[ln] = 1'b0; s_last[ln] = 1'b0;
  endtask

  task automatic wait_fs(input int ln, input int target, input int lim);
    int k;
    k = 0;
    while (get_fs(ln) != target && k < lim) begin @(negedge clk); k++; end
    check("fs_reached", ln, get_fs(ln), target);
    step(1);
  endtask

  task automatic wait_starts(input int ln, input int target, input int lim);
    int k;
    k = 0;
    while (scnt[ln] < target && k < lim) begin @(negedge clk); k++; end
    check("start_seen", ln, scnt[ln], target);
    step(1);
  endtask

  task automatic wait_err(input int ln, input int lim, output int at_cyc);
    int k;
    k = 0;
    while (err[ln] !== 1'b1 && k < lim) begin @(negedge clk); k++; end
    at_cyc = cyc;
    check("err_seen", ln, err[ln], 1);
    step(1);
  endtask

  task automatic wait_idle(input int ln, input int lim);
    int k;
    k = 0;
    while (!(m_qn[ln] == 0 && m_ph[ln] == 0 && m_nb[ln] == 0) && k < lim) begin
      @(negedge clk); k++;
    end
    check("drain_busy", ln, busy[ln], 0);
    step(1);
  endtask

  task automatic rand_lane(input int ln, input int nframes);
    int   len;
    logic l;
    for (int f = 0; f < nframes; f++) begin
      len = $urandom_range(8, 1);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3, 0) == 0) step($urandom_range(2, 1));
        if (k == len - 1) l = (len < 8) ? 1'b1 : 1'(($urandom_range(1, 0)));
        else              l = 1'b0;
        send_byte(ln, 8'($urandom_range(255, 0)), l);
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] w;
    int          t_err;
    int          sc_before;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_data[i] = 8'd0;
    end
    @(posedge clk); #1;
    chk_en = 1;
    step(3);
    rst[0] = 1'b0; rst[1] = 1'b0;
    step(1);
    check("reset_fs", 0, fs0, 0);
    check("reset_dout", 0, dout0, 0);
    check("reset_dout", 1, dout1, 0);

    // Full frame, MSB first, encoder answers 10 cycles after start.
    auto_m[0] = 1; dly[0] = 10;
    for (int k = 1; k <= 8; k++) send_byte(0, 8'(k), 1'b0);
    wait_fs(0, 1, 200);
    check("full_frame_data", 0, dout0, 64'h0102030405060708);
    check("full_frame_starts", 0, scnt[0], 1);

    // Short frame, LSB first.
    auto_m[1] = 1; dly[1] = 5;
    send_byte(1, 8'hAA, 1'b0);
    send_byte(1, 8'hBB, 1'b0);
    send_byte(1, 8'hCC, 1'b1);
    wait_fs(1, 1, 200);
    check("short_frame_data", 1, dout1, 64'h0000000000CCBBAA);

    // Backpressure: 24 bytes back to back, 40-cycle encoder.
    dly[0] = 40; bp_watch = 1; acc_base = acc[0]; stall_at = -1;
    for (int k = 0; k < 24; k++) send_byte(0, 8'(8'h10 + k), 1'b0);
    wait_fs(0, 4, 1000);
    bp_watch = 0;
    check("bp_stall_after", 0, stall_at, 16);
    check("bp_starts", 0, scnt[0], 4);
    for (int j = 0; j < 3; j++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w = {w[55:0], 8'(8'h10 + 8 * j + b)};
      check("bp_frame_order", 0, (log0.size() > j + 1) ? log0[j + 1] : 64'hX, w);
    end

    // Timeout on lane 1 (TIMEOUT=16), then a normal frame still issues.
    auto_m[1] = 0; man_done[1] = 1'b0;
    send_byte(1, 8'h11, 1'b0);
    send_byte(1, 8'h22, 1'b1);
    wait_err(1, 200, t_err);
    check("timeout_latency", 1, t_err - last_start_cyc[1], 17);
    check("timeout_fs_kept", 1, fs1, 1);
    check("timeout_frame", 1, dout1, 64'h0000000000002211);
    auto_m[1] = 1; dly[1] = 3;
    send_byte(1, 8'h33, 1'b1);
    wait_fs(1, 2, 200);
    check("after_timeout_data", 1, dout1, 64'h33);
    check("err_sticky", 1, err[1], 1);

    // done already high before ISSUE: only a fresh rise completes.
    auto_m[0] = 0; man_done[0] = 1'b1;
    step(2);
    sc_before = scnt[0];
    for (int k = 0; k < 8; k++) send_byte(0, 8'(8'h30 + k), 1'b0);
    wait_starts(0, sc_before + 1, 100);
    step(10);
    check("level_no_complete", 0, fs0, 4);
    check("level_busy", 0, busy[0], 1);
    man_done[0] = 1'b0;
    step(3);
    man_done[0] = 1'b1;
    step(3);
    check("level_complete", 0, fs0, 5);
    man_done[0] = 1'b0;
    step(2);

    // Reset while waiting with 5 bytes in assembly.
    sc_before = scnt[0];
    for (int k = 0; k < 8; k++) send_byte(0, 8'(8'h40 + k), 1'b0);
    wait_starts(0, sc_before + 1, 100);
    for (int k = 0; k < 5; k++) send_byte(0, 8'(8'h50 + k), 1'b0);
    step(2);
    sc_before = scnt[0];
    rst[0] = 1'b1;
    step(2);
    rst[0] = 1'b0;
    step(4);
    check("rst_fs", 0, fs0, 0);
    check("rst_dout", 0, dout0, 0);
    check("rst_busy", 0, busy[0], 0);
    check("rst_no_start", 0, scnt[0], sc_before);
    auto_m[0] = 1; dly[0] = 4;
    for (int k = 0; k < 8; k++) send_byte(0, 8'(8'hA0 + k), 1'b0);
    wait_fs(0, 1, 200);
    check("rst_clean_frame", 0, dout0, 64'hA0A1A2A3A4A5A6A7);

    // Random traffic on both lanes; lane 1 sees timeouts and counter wrap.
    auto_m[0] = 2; dmax[0] = 20;
    auto_m[1] = 2; dmax[1] = 24;
    fork
      rand_lane(0, 50);
      rand_lane(1, 50);
    join
    wait_idle(0, 3000);
    wait_idle(1, 3000);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

endmodule
